// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding,
// opcode/funct constants and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        FETCH_IR,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        R_EXEC,
        R_WB,
        I_EXEC,
        I_WB,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_IMM10  = 6'h10;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;

    localparam logic [5:0] ALUOP_ADD   = 6'h09;
    localparam logic [5:0] ALUOP_RTYPE = 6'h00;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic imm_is_signed(input logic [5:0] op);
        return !(op == OP_ANDI || op == OP_ORI || op == OP_XORI);
    endfunction

endpackage

// File: rtl/controller.sv
// Multi-cycle Moore controller for the MIPS-style datapath.
// Optional HALT state (opcode 0x3F) is enabled by defining CTRL_HALT_EN.
module controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] ir_opcode,
    input  logic [5:0] ir_funct,
    input  logic       branch_taken,
    output logic       pc_write_en,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       jump_and_link,
    output logic       is_signed,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [5:0] alu_op,
    output logic       halted
);

    state_t state, next_state;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        unique case (state)
            FETCH:    next_state = FETCH_IR;
            FETCH_IR: next_state = DECODE;
            DECODE: begin
                unique case (ir_opcode)
                    OP_LW, OP_SW:  next_state = MEM_ADDR;
                    OP_RTYPE:      next_state = R_EXEC;
                    OP_ADDIU, OP_IMM10, OP_ANDI, OP_ORI, OP_XORI,
                    OP_SLTI, OP_SLTIU:
                                   next_state = I_EXEC;
                    OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                                   next_state = BRANCH;
                    OP_J, OP_JAL:  next_state = JUMP;
`ifdef CTRL_HALT_EN
                    OP_HALT:       next_state = HALT;
`endif
                    default:       next_state = FETCH;
                endcase
            end
            MEM_ADDR:  next_state = (ir_opcode == OP_SW) ? MEM_WRITE
                                  : (ir_opcode == OP_LW) ? MEM_READ : FETCH;
            MEM_READ:  next_state = MEM_WB;
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: next_state = FETCH;
            R_EXEC: begin
                if (ir_funct == FN_JR || ir_funct == FN_MULT || ir_funct == FN_MULTU)
                    next_state = FETCH;
                else
                    next_state = R_WB;
            end
            R_WB:      next_state = FETCH;
            I_EXEC:    next_state = I_WB;
            I_WB:      next_state = FETCH;
            BRANCH:    next_state = FETCH;
            JUMP:      next_state = FETCH;
`ifdef CTRL_HALT_EN
            HALT:      next_state = HALT;
`else
            HALT:      next_state = FETCH;
`endif
            default:   next_state = FETCH;
        endcase
    end

    always_comb begin
        pc_write_en   = 1'b0;
        i_or_d        = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        jump_and_link = 1'b0;
        is_signed     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 6'h00;
        halted        = 1'b0;

        unique case (state)
            FETCH: ;
            FETCH_IR: begin
                ir_write    = 1'b1;
                alu_src_b   = 2'b01;
                alu_op      = ALUOP_ADD;
                pc_write_en = 1'b1;
            end
            DECODE: begin
                // Branch target computed speculatively while decoding.
                alu_src_b = 2'b11;
                alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
                is_signed = 1'b1;
            end
            MEM_READ: i_or_d = 1'b1;
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_RTYPE;
                if (ir_funct == FN_JR) pc_write_en = 1'b1;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_op    = ALUOP_RTYPE;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ir_opcode;
                is_signed = imm_is_signed(ir_opcode);
            end
            I_WB: begin
                reg_write = 1'b1;
                alu_op    = ir_opcode;
                is_signed = imm_is_signed(ir_opcode);
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_op      = ir_opcode;
                is_signed   = 1'b1;
                pc_source   = 2'b01;
                pc_write_en = branch_taken;
            end
            JUMP: begin
                pc_source   = 2'b10;
                pc_write_en = 1'b1;
                if (ir_opcode == OP_JAL) begin
                    reg_write     = 1'b1;
                    jump_and_link = 1'b1;
                end
            end
`ifdef CTRL_HALT_EN
            HALT: halted = 1'b1;
`else
            HALT: ;
`endif
            default: ;
        endcase

        // Enables must be quiet during reset regardless of the state being left.
        if (rst) begin
            pc_write_en = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            mem_write   = 1'b0;
            halted      = 1'b0;
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: instruction-level reference model
// compared every cycle, plus hand-computed pins on selected instructions.
module tb_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] ir_opcode, ir_funct;
    logic       branch_taken;
    logic       pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst;
    logic       reg_write, alu_src_a, jump_and_link, is_signed, halted;
    logic [1:0] alu_src_b, pc_source;
    logic [5:0] alu_op;

    typedef struct packed {
        logic       pc_write_en;
        logic       i_or_d;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       jump_and_link;
        logic       is_signed;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [5:0] alu_op;
        logic       halted;
    } ctl_t;

    controller dut (
        .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ir_funct(ir_funct),
        .branch_taken(branch_taken), .pc_write_en(pc_write_en), .i_or_d(i_or_d),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .ir_write(ir_write),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .jump_and_link(jump_and_link), .is_signed(is_signed), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .alu_op(alu_op), .halted(halted)
    );

    always #5 clk = ~clk;

    ctl_t act;
    assign act = {pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst,
                  reg_write, alu_src_a, jump_and_link, is_signed, alu_src_b,
                  pc_source, alu_op, halted};

    int n_total = 0;
    int n_pass  = 0;

    // 0 idle, 1 instruction in progress, 2 reset asserted
    int mode = 0;
    int step = 0;
    int cur_len = 0;
    ctl_t trace [0:63];

    function automatic bit is_imm(input logic [5:0] op);
        return op inside {6'h09, 6'h10, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B};
    endfunction

    function automatic bit is_br(input logic [5:0] op);
        return op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
    endfunction

    function automatic bit halt_on;
`ifdef CTRL_HALT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Cycles an instruction occupies, counting from its FETCH cycle.
    function automatic int instr_len(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00)                 return (fn inside {6'h08, 6'h18, 6'h19}) ? 4 : 5;
        if (op == 6'h23)                 return 6;
        if (op == 6'h2B)                 return 5;
        if (is_imm(op))                  return 5;
        if (is_br(op))                   return 4;
        if (op == 6'h02 || op == 6'h03)  return 4;
        if (op == 6'h3F && halt_on())    return 23;
        return 3;
    endfunction

    // What the datapath must see on cycle s of an instruction.
    function automatic ctl_t exp_ctl(input logic [5:0] op, input logic [5:0] fn,
                                     input logic bt, input int s);
        ctl_t o = '0;
        if (s == 1) begin
            o.ir_write = 1; o.alu_src_b = 2'b01; o.alu_op = 6'h09; o.pc_write_en = 1;
        end else if (s == 2) begin
            o.alu_src_b = 2'b11; o.alu_op = 6'h09;
        end else if (s >= 3) begin
            if (op == 6'h23 || op == 6'h2B) begin
                if (s == 3) begin
                    o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 6'h09; o.is_signed = 1;
                end else if (s == 4) begin
                    o.i_or_d = 1;
                    o.mem_write = (op == 6'h2B);
                end else begin
                    o.reg_write = 1; o.mem_to_reg = 1;
                end
            end else if (op == 6'h00) begin
                if (s == 3) begin
                    o.alu_src_a = 1;
                    o.pc_write_en = (fn == 6'h08);
                end else begin
                    o.reg_write = 1; o.reg_dst = 1;
                end
            end else if (is_imm(op)) begin
                o.alu_op = op;
                o.is_signed = !(op inside {6'h0C, 6'h0D, 6'h0E});
                if (s == 3) begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
                else        o.reg_write = 1;
            end else if (is_br(op)) begin
                o.alu_src_a = 1; o.alu_op = op; o.is_signed = 1;
                o.pc_source = 2'b01; o.pc_write_en = bt;
            end else if (op == 6'h02 || op == 6'h03) begin
                o.pc_source = 2'b10; o.pc_write_en = 1;
                o.reg_write = (op == 6'h03); o.jump_and_link = (op == 6'h03);
            end else if (op == 6'h3F && halt_on()) begin
                o.halted = 1;
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: op=%h funct=%h step=%0d got %h expected %h",
                      name, ir_opcode, ir_funct, step, a, e);
    endtask

    // Hand-computed expectations for selected instructions, from the trace.
    task automatic pin_checks;
        case (ir_opcode)
            6'h00: if (ir_funct == 6'h21) begin
                chk("r_regwrite_seq", {trace[0].reg_write, trace[1].reg_write, trace[2].reg_write,
                                       trace[3].reg_write, trace[4].reg_write}, 32'b00001);
                chk("r_regdst_seq", {trace[0].reg_dst, trace[1].reg_dst, trace[2].reg_dst,
                                     trace[3].reg_dst, trace[4].reg_dst}, 32'b00001);
            end
            6'h23: begin
                chk("lw_read_iord", trace[4].i_or_d, 1);
                chk("lw_wb", {trace[5].reg_write, trace[5].mem_to_reg, trace[5].reg_dst}, 32'b110);
            end
            6'h2B: begin
                chk("sw_memwrite_seq", {trace[0].mem_write, trace[1].mem_write, trace[2].mem_write,
                                        trace[3].mem_write, trace[4].mem_write}, 32'b00001);
                chk("sw_iord", trace[4].i_or_d, 1);
            end
            6'h04: chk("beq_pc", {trace[3].pc_write_en, trace[3].pc_source},
                       branch_taken ? 32'b101 : 32'b001);
            6'h03: chk("jal_ctl", {trace[3].pc_source, trace[3].pc_write_en, trace[3].reg_write,
                                   trace[3].jump_and_link}, 32'b10111);
            6'h02: chk("j_ctl", {trace[3].pc_source, trace[3].pc_write_en, trace[3].reg_write,
                                 trace[3].jump_and_link}, 32'b10100);
            6'h0C: chk("andi_unsigned", {trace[3].is_signed, trace[3].alu_op}, 32'h0C);
            6'h3F: chk("halt_last", {trace[cur_len-1].halted, trace[cur_len-1].pc_write_en},
                       halt_on() ? 32'b10 : 32'b00);
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (mode == 2) begin
            chk("reset_enables", {pc_write_en, ir_write, reg_write, mem_write, halted}, 0);
        end else if (mode == 1) begin
            chk("cycle", act, exp_ctl(ir_opcode, ir_funct, branch_taken, step));
            trace[step] = act;
            if (step == cur_len - 1) pin_checks();
        end
    end

    // n < 0 runs the whole instruction; otherwise stop after n cycles.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic bt, input int n);
        int len;
        ir_opcode = op; ir_funct = fn; branch_taken = bt;
        len = instr_len(op, fn);
        cur_len = len;
        if (n >= 0 && n < len) len = n;
        for (int s = 0; s < len; s++) begin
            step = s; mode = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1; mode = 2;
        repeat (cycles) begin @(posedge clk); #1; end
        rst = 0; mode = 0;
    endtask

    initial begin
        ir_opcode = 6'h00; ir_funct = 6'h00; branch_taken = 1'b0;
        do_reset(2);

        run(6'h00, 6'h21, 0, -1);
        run(6'h23, 6'h00, 0, -1);
        run(6'h2B, 6'h00, 1, -1);
        run(6'h04, 6'h00, 1, -1);
        run(6'h04, 6'h00, 0, -1);
        run(6'h03, 6'h00, 0, -1);
        run(6'h02, 6'h00, 1, -1);
        run(6'h00, 6'h08, 1, -1);
        run(6'h00, 6'h18, 0, -1);
        run(6'h00, 6'h19, 0, -1);
        run(6'h09, 6'h00, 0, -1);
        run(6'h0C, 6'h00, 1, -1);
        run(6'h0E, 6'h00, 0, -1);
        run(6'h0A, 6'h00, 0, -1);
        run(6'h10, 6'h00, 0, -1);
        run(6'h05, 6'h00, 0, -1);
        run(6'h07, 6'h00, 1, -1);
        run(6'h01, 6'h00, 1, -1);
        run(6'h11, 6'h00, 1, -1);

        // Reset in the middle of a load, with the read enable live.
        run(6'h23, 6'h00, 1, 5);
        do_reset(1);
        run(6'h2B, 6'h00, 0, -1);

        // 0x3F: HALT when enabled, otherwise an unknown opcode.
        run(6'h3F, 6'h00, 0, -1);
        if (halt_on()) do_reset(1);
        run(6'h00, 6'h21, 0, -1);
        run(6'h23, 6'h00, 0, -1);

        mode = 0;
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port ir_opcode, input, 6 bits: instruction register bits [31:26].
REQ-004 SHALL have port ir_funct, input, 6 bits: instruction register bits [5:0].
REQ-005 SHALL have port branch_taken, input, 1 bit: branch compare result from the datapath ALU.
REQ-006 SHALL have outputs pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a, jump_and_link and is_signed, each 1 bit, each driving the datapath input of the same name.
REQ-007 SHALL have outputs alu_src_b (2 bits), pc_source (2 bits) and alu_op (6 bits), each driving the datapath input of the same name.
REQ-008 SHALL have port halted, output, 1 bit: high while the controller is in HALT.

Function
REQ-009 SHALL implement a multi-cycle Moore FSM with states FETCH, FETCH_IR, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP and HALT.
REQ-010 SHALL derive outputs combinationally from the current state, ir_opcode and ir_funct only; pc_write_en in BRANCH SHALL also use branch_taken.
REQ-011 SHALL drive every output not explicitly asserted in a state to 0.
REQ-012 FETCH: i_or_d=0, no write enables; next state FETCH_IR.
REQ-013 FETCH_IR: ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ALUOP_ADD, pc_source=00, pc_write_en=1; next state DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=ALUOP_ADD (precomputes the branch target).
REQ-015 DECODE next state by opcode: 0x23/0x2B go to MEM_ADDR; 0x00 goes to R_EXEC; 0x09, 0x10, 0x0C, 0x0D, 0x0E, 0x0A and 0x0B go to I_EXEC; 0x01, 0x04, 0x05, 0x06 and 0x07 go to BRANCH; 0x02/0x03 go to JUMP; 0x3F per REQ-029; any other opcode goes to FETCH with no side effect.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ALUOP_ADD, is_signed=1; next state MEM_READ for 0x23, MEM_WRITE for 0x2B.
REQ-017 MEM_READ: i_or_d=1; next state MEM_WB.
REQ-018 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-019 MEM_WRITE: i_or_d=1, mem_write=1 for exactly one cycle; next state FETCH.
REQ-020 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=0x00.
REQ-021 R_EXEC with funct 0x08 (jr): pc_source=00, pc_write_en=1, next state FETCH; with funct 0x18/0x19 (mult): next state FETCH; any other funct: next state R_WB.
REQ-022 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_op=0x00; next state FETCH.
REQ-023 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ir_opcode; is_signed=0 for 0x0C/0x0D/0x0E and 1 otherwise; next state I_WB.
REQ-024 I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, with alu_op and is_signed as in I_EXEC; next state FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=ir_opcode, is_signed=1, pc_source=01, pc_write_en=branch_taken; next state FETCH.
REQ-026 JUMP: pc_source=10, pc_write_en=1; additionally reg_write=1 and jump_and_link=1 when opcode is 0x03; next state FETCH.
REQ-027 halted SHALL be 1 only in HALT.

Reset
REQ-028 While rst=1, pc_write_en, ir_write, reg_write, mem_write and halted SHALL be 0; state SHALL be FETCH after the edge, from any state including HALT and mid-instruction.

Configuration
REQ-029 With macro CTRL_HALT_EN defined, opcode 0x3F in DECODE SHALL go to HALT, which asserts no enables and holds until rst; without it, 0x3F SHALL be treated as an unknown opcode (DECODE to FETCH) and halted SHALL be tied 0.

Structure
REQ-030 The state enum, the opcode/funct constants and ALUOP_ADD (6'h09) SHALL reside in the shared package ctrl_pkg.
REQ-031 The block SHALL contain no sub-module; the state register and the output decode SHALL be separate processes.

Verification
REQ-032 Reset 2 cycles, then opcode 0x00 with funct 0x21 -> FETCH, FETCH_IR, DECODE, R_EXEC, R_WB; reg_write=1 and reg_dst=1 in cycle 5 only.
REQ-033 Opcode 0x23 -> 6 cycles; i_or_d=1 in MEM_READ; MEM_WB has reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-034 Opcode 0x2B -> 5 cycles; mem_write=1 for exactly one cycle, with i_or_d=1.
REQ-035 Opcode 0x04 with branch_taken=1 -> BRANCH has pc_write_en=1 and pc_source=01; with branch_taken=0 -> pc_write_en=0.
REQ-036 Opcode 0x03 -> JUMP has pc_source=10, pc_write_en=1, reg_write=1, jump_and_link=1; opcode 0x02 -> same, but reg_write=0.
REQ-037 CTRL_HALT_EN defined and opcode 0x3F -> halted=1 and zero enables for 20 cycles; rst -> FETCH. Macro undefined -> returns to FETCH after DECODE.
